// File: rtl/store_control_pkg.sv
// Shared opcodes, FSM state type and opcode helpers for the store path.
package store_control_pkg;

  localparam logic [5:0] OPCODE_LB  = 6'h20;
  localparam logic [5:0] OPCODE_LH  = 6'h21;
  localparam logic [5:0] OPCODE_LW  = 6'h23;
  localparam logic [5:0] OPCODE_LBU = 6'h24;
  localparam logic [5:0] OPCODE_LHU = 6'h25;
  localparam logic [5:0] OPCODE_SB  = 6'h28;
  localparam logic [5:0] OPCODE_SH  = 6'h29;
  localparam logic [5:0] OPCODE_SW  = 6'h2B;

  typedef enum logic [0:0] {STORE_IDLE, STORE_WRITE} store_state_t;

  function automatic logic is_store(input logic [5:0] op);
    return (op == OPCODE_SB) || (op == OPCODE_SH) || (op == OPCODE_SW);
  endfunction

endpackage

// File: rtl/store_control_if.sv
// Avalon-style write-only master bus between store_control and data memory.
interface store_control_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_writedata;
  logic              avm_waitrequest;

  modport master (
    output avm_address, avm_write, avm_byteenable, avm_writedata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_write, avm_byteenable, avm_writedata,
    output avm_waitrequest
  );
endinterface

// File: rtl/store_lane_mux.sv
// Builds little-endian byte lanes and replicated write data for SB/SH/SW.
module store_lane_mux
  import store_control_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  lsb,
  input  logic [31:0] store_data,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic        misaligned
);

  always_comb begin
    byteenable = 4'b0000;
    writedata  = store_data;
    misaligned = 1'b0;
    case (opcode)
      OPCODE_SB: begin
        byteenable = 4'b0001 << lsb;
        writedata  = {4{store_data[7:0]}};
      end
      OPCODE_SH: begin
        byteenable = lsb[1] ? 4'b1100 : 4'b0011;
        writedata  = {2{store_data[15:0]}};
        misaligned = lsb[0];
      end
      OPCODE_SW: begin
        byteenable = 4'b1111;
        misaligned = |lsb;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_control.sv
// Store-side bus master: accepts SB/SH/SW, issues one Avalon write, stalls the CPU until accepted.
module store_control
  import store_control_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        opcode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  store_control_if.master   avm,
  output logic              stall,
  output logic              done,
  output logic              addr_error
);

  store_state_t state_q, state_d;

  logic [3:0]  lane_be;
  logic [31:0] lane_wd;
  logic        lane_misaligned;

  logic take, go, reject;
  logic req_ready_d, write_d, stall_d, done_d, addr_error_d;

  store_lane_mux u_lane_mux (
    .opcode     (opcode),
    .lsb        (addr[1:0]),
    .store_data (store_data),
    .byteenable (lane_be),
    .writedata  (lane_wd),
    .misaligned (lane_misaligned)
  );

  // req_ready is only high in IDLE, so take cannot fire while a write is in flight
  assign take   = req_valid && req_ready && (state_q == STORE_IDLE) && is_store(opcode);
  assign go     = take && !lane_misaligned;
  assign reject = take && lane_misaligned;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= STORE_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      STORE_IDLE:  if (go) state_d = STORE_WRITE;
      STORE_WRITE: if (!avm.avm_waitrequest) state_d = STORE_IDLE;
      default:     state_d = STORE_IDLE;
    endcase
  end

  always_comb begin
    req_ready_d  = 1'b1;
    write_d      = 1'b0;
    stall_d      = 1'b0;
    done_d       = 1'b0;
    addr_error_d = 1'b0;
    case (state_q)
      STORE_IDLE: begin
        addr_error_d = reject;
        if (go) begin
          req_ready_d = 1'b0;
          write_d     = 1'b1;
          stall_d     = 1'b1;
        end
      end
      STORE_WRITE: begin
        if (avm.avm_waitrequest) begin
          req_ready_d = 1'b0;
          write_d     = 1'b1;
          stall_d     = 1'b1;
        end else begin
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_ready      <= 1'b0;
      avm.avm_write  <= 1'b0;
      stall          <= 1'b0;
      done           <= 1'b0;
      addr_error     <= 1'b0;
    end else begin
      req_ready      <= req_ready_d;
      avm.avm_write  <= write_d;
      stall          <= stall_d;
      done           <= done_d;
      addr_error     <= addr_error_d;
    end
  end

  // Bus payload only loads on acceptance, so it stays frozen across waitrequest
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm.avm_address    <= '0;
      avm.avm_byteenable <= 4'b0000;
      avm.avm_writedata  <= 32'h0;
    end else if (go) begin
      avm.avm_address    <= {addr[ADDR_W-1:2], 2'b00};
      avm.avm_byteenable <= lane_be;
      avm.avm_writedata  <= lane_wd;
    end
  end

endmodule

// File: tb/tb_store_control.sv
// Scoreboard bench for store_control: directed stores, misaligned rejects, reset abort.
module tb_store_control;
  import store_control_pkg::*;

  localparam int ADDR_W = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [5:0]  opcode = 6'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        req_ready, stall, done, addr_error;

  store_control_if #(.ADDR_W(ADDR_W)) bus ();

  store_control #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .opcode     (opcode),
    .addr       (addr),
    .store_data (store_data),
    .avm        (bus),
    .stall      (stall),
    .done       (done),
    .addr_error (addr_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int done_exp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: peek the head entry on every cycle the bus is driven, pop on acceptance
  always @(negedge clk) begin
    if (reset_n) begin
      if (done) done_seen++;
      if (done && addr_error) chk("done_err_overlap", 32'd1, 32'd0);
      if (addr_error) begin
        if (q.size() == 0) chk("unexpected_addr_error", 32'd1, 32'd0);
        else begin
          chk("addr_error_kind", 32'(q[0].err), 32'd1);
          q.pop_front();
        end
      end
      if (bus.avm_write) begin
        if (q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          chk("write_kind", 32'(q[0].err), 32'd0);
          chk("avm_address", bus.avm_address, q[0].a);
          chk("avm_byteenable", 32'(bus.avm_byteenable), 32'(q[0].be));
          chk("avm_writedata", bus.avm_writedata, q[0].d);
          if (!bus.avm_waitrequest) q.pop_front();
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic do_store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] ea, input logic [3:0] be, input logic [31:0] wd,
                          input int waits);
    exp_t e;
    wait_ready();
    opcode = op; addr = a; store_data = d; req_valid = 1'b1;
    bus.avm_waitrequest = (waits > 0);
    e.err = 1'b0; e.a = ea; e.be = be; e.d = wd;
    q.push_back(e);
    done_exp++;
    tick();
    req_valid = 1'b0;
    chk("stall_on_accept", 32'(stall), 32'd1);
    chk("ready_low_in_write", 32'(req_ready), 32'd0);
    for (int i = 0; i < waits; i++) begin
      tick();
      chk("stall_hold", 32'(stall), 32'd1);
      chk("no_early_done", 32'(done), 32'd0);
    end
    bus.avm_waitrequest = 1'b0;
    tick();
    chk("done_pulse", 32'(done), 32'd1);
    chk("stall_release", 32'(stall), 32'd0);
    chk("write_drop", 32'(bus.avm_write), 32'd0);
    chk("ready_with_done", 32'(req_ready), 32'd1);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic do_err(input logic [5:0] op, input logic [31:0] a);
    exp_t e;
    wait_ready();
    opcode = op; addr = a; store_data = 32'hFFFF_FFFF; req_valid = 1'b1;
    e.err = 1'b1; e.a = 32'h0; e.be = 4'h0; e.d = 32'h0;
    q.push_back(e);
    tick();
    req_valid = 1'b0;
    chk("addr_error_pulse", 32'(addr_error), 32'd1);
    chk("err_no_write", 32'(bus.avm_write), 32'd0);
    chk("err_no_stall", 32'(stall), 32'd0);
    chk("err_ready_stays", 32'(req_ready), 32'd1);
    tick();
    chk("addr_error_one_cycle", 32'(addr_error), 32'd0);
    chk("err_still_no_write", 32'(bus.avm_write), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    bus.avm_waitrequest = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_avm_write", 32'(bus.avm_write), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_addr_error", 32'(addr_error), 32'd0);
      chk("rst_avm_address", bus.avm_address, 32'h0);
      chk("rst_avm_byteenable", 32'(bus.avm_byteenable), 32'd0);
      chk("rst_avm_writedata", bus.avm_writedata, 32'h0);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    chk("ready_before_edge", 32'(req_ready), 32'd0);
    tick();
    chk("ready_after_release", 32'(req_ready), 32'd1);

    do_store(OPCODE_SB, 32'h0000_1003, 32'h0000_00A5, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 0);
    do_store(OPCODE_SH, 32'h0000_2002, 32'h1234_BEEF, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 3);
    do_err  (OPCODE_SW, 32'h0000_3001);
    do_store(OPCODE_SW, 32'h0000_3000, 32'hDEAD_BEEF, 32'h0000_3000, 4'b1111, 32'hDEAD_BEEF, 0);
    do_store(OPCODE_SB, 32'h0000_5002, 32'h0000_00C3, 32'h0000_5000, 4'b0100, 32'hC3C3_C3C3, 1);
    do_store(OPCODE_SH, 32'h0000_6000, 32'hCAFE_0001, 32'h0000_6000, 4'b0011, 32'h0001_0001, 0);
    do_err  (OPCODE_SH, 32'h0000_6001);
    do_store(OPCODE_SB, 32'h0000_1001, 32'h0000_005A, 32'h0000_1000, 4'b0010, 32'h5A5A_5A5A, 0);

    // Load opcode must be ignored
    wait_ready();
    opcode = OPCODE_LBU; addr = 32'h0000_7001; store_data = 32'h1111_2222; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("lbu_no_write", 32'(bus.avm_write), 32'd0);
    chk("lbu_no_stall", 32'(stall), 32'd0);
    chk("lbu_no_error", 32'(addr_error), 32'd0);
    chk("lbu_ready", 32'(req_ready), 32'd1);
    tick();
    chk("lbu_no_done", 32'(done), 32'd0);
    chk("lbu_still_no_write", 32'(bus.avm_write), 32'd0);

    // Reset while a write is stuck on waitrequest
    wait_ready();
    opcode = OPCODE_SW; addr = 32'h0000_8000; store_data = 32'h0102_0304; req_valid = 1'b1;
    bus.avm_waitrequest = 1'b1;
    e.err = 1'b0; e.a = 32'h0000_8000; e.be = 4'b1111; e.d = 32'h0102_0304;
    q.push_back(e);
    tick();
    req_valid = 1'b0;
    chk("abort_write_up", 32'(bus.avm_write), 32'd1);
    tick();
    #1 reset_n = 1'b0;
    #1;
    chk("abort_write_async", 32'(bus.avm_write), 32'd0);
    chk("abort_stall_async", 32'(stall), 32'd0);
    chk("abort_ready_async", 32'(req_ready), 32'd0);
    q.delete();
    tick();
    chk("abort_no_done", 32'(done), 32'd0);
    tick();
    bus.avm_waitrequest = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("abort_ready_after_release", 32'(req_ready), 32'd1);
    chk("abort_no_done_after", 32'(done), 32'd0);

    do_store(OPCODE_SB, 32'h0000_4001, 32'h0000_007E, 32'h0000_4000, 4'b0010, 32'h7E7E_7E7E, 0);

    repeat (3) tick();
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("done_count", 32'(done_seen), 32'(done_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
